// File: rtl/led_blink_pkg.sv
// ---------------------------------------------------------------------------
// led_blink_pkg
// Shared types and width helpers for the LED blink output path.
//
// Contents:
//   blink_state_t : blink FSM states (IDLE, ON, GAP)
//   calc_pw       : width of the pending-blink counter for a given maximum
//   calc_tw       : width of the ON/OFF window timer, never less than 1 bit
// ---------------------------------------------------------------------------
package led_blink_pkg;

  // Blink sequencer states. ON is the only state that lights the LED.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } blink_state_t;

  // Bits needed to hold a pending count from 0 up to maxPending inclusive.
  function automatic int calc_pw(input int maxPending);
    int w;
    w = $clog2(maxPending + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  // The timer only ever holds (window length - 1), so $clog2 of the longer
  // window is enough. Both windows of length 1 would give 0 bits, which is
  // not a legal vector, so the result is clamped to 1.
  function automatic int calc_tw(input int onCycles, input int offCycles);
    int longest;
    int w;
    longest = (onCycles > offCycles) ? onCycles : offCycles;
    w = $clog2(longest);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/led_blink_output_counter.sv
// ---------------------------------------------------------------------------
// sat_up_down_counter
// Saturating up/down counter used as the queue of blinks waiting to start.
//
// Parameters:
//   MAX      : highest count held; further increments are dropped
// Ports:
//   clk      : system clock
//   reset    : asynchronous reset, active low
//   inc      : add one this edge (ignored at MAX unless dec is also high)
//   dec      : subtract one this edge (ignored at zero)
//   count    : current count
//   overflow : one-cycle registered pulse after an increment was dropped
// ---------------------------------------------------------------------------
module sat_up_down_counter
  import led_blink_pkg::*;
#(
  parameter int MAX = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inc,
  input  logic                     dec,
  output logic [calc_pw(MAX)-1:0]  count,
  output logic                     overflow
);

  localparam int W = calc_pw(MAX);
  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_count;
  logic         r_overflow;
  logic [W-1:0] w_countNext;
  logic         w_overflowNext;

  // Simultaneous inc and dec cancel, so a full queue still accepts a new
  // request on the same edge that one leaves it.
  always_comb begin
    w_countNext    = r_count;
    w_overflowNext = 1'b0;
    if (inc && !dec) begin
      if (r_count == MAX_V) begin
        w_overflowNext = 1'b1;
      end else begin
        w_countNext = r_count + W'(1);
      end
    end else if (!inc && dec) begin
      if (r_count != '0) begin
        w_countNext = r_count - W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_count    <= w_countNext;
      r_overflow <= w_overflowNext;
    end
  end

  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: rtl/led_blink_output.sv
// ---------------------------------------------------------------------------
// led_blink_output
// Turns single-cycle event pulses from control logic into visible blinks on
// an active-low board indicator. Each blink is ON_CYCLES lit followed by an
// OFF_CYCLES dark gap. Pulses arriving mid-blink are queued (up to
// MAX_PENDING) so a burst of events produces the same number of blinks.
//
// Parameters:
//   ON_CYCLES   : cycles the LED is lit per blink (>= 1)
//   OFF_CYCLES  : cycles of forced dark gap after each blink (>= 1)
//   MAX_PENDING : maximum number of queued blinks
// Ports:
//   clk     : system clock
//   reset   : asynchronous reset, active low
//   trigger : event pulse, one high cycle = one blink
//   led     : indicator drive, 0 = lit, 1 = dark
//   busy    : a blink is running or queued
//   pending : number of queued blinks not yet started
//   dropped : one-cycle pulse when a trigger was lost to a full queue
// ---------------------------------------------------------------------------
module led_blink_output
  import led_blink_pkg::*;
#(
  parameter int ON_CYCLES   = 4,
  parameter int OFF_CYCLES  = 4,
  parameter int MAX_PENDING = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             trigger,
  output logic                             led,
  output logic                             busy,
  output logic [calc_pw(MAX_PENDING)-1:0]  pending,
  output logic                             dropped
);

  localparam int PW = calc_pw(MAX_PENDING);
  localparam int TW = calc_tw(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  blink_state_t  r_state;
  blink_state_t  w_stateNext;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timerNext;
  logic          w_startBlink;
  logic [PW-1:0] w_pending;
  logic          w_overflow;
  logic          w_havePending;

  assign w_havePending = (w_pending != '0);

  // Queue of blinks waiting to start. A trigger adds one, each blink start
  // removes one.
  sat_up_down_counter #(
    .MAX (MAX_PENDING)
  ) u_pendingCounter (
    .clk      (clk),
    .reset    (reset),
    .inc      (trigger),
    .dec      (w_startBlink),
    .count    (w_pending),
    .overflow (w_overflow)
  );

  // State and window timer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_stateNext;
      r_timer <= w_timerNext;
    end
  end

  // The timer counts down to zero within each window; the edge on which it
  // reads zero is the last cycle of that window. At the end of the gap a
  // queued blink starts directly, so back-to-back blinks have no idle cycle
  // between them.
  always_comb begin
    w_stateNext  = r_state;
    w_timerNext  = r_timer;
    w_startBlink = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_havePending) begin
          w_stateNext  = ON;
          w_timerNext  = ON_LOAD;
          w_startBlink = 1'b1;
        end
      end
      ON: begin
        if (r_timer == '0) begin
          w_stateNext = GAP;
          w_timerNext = OFF_LOAD;
        end else begin
          w_timerNext = r_timer - TW'(1);
        end
      end
      GAP: begin
        if (r_timer != '0) begin
          w_timerNext = r_timer - TW'(1);
        end else if (w_havePending) begin
          w_stateNext  = ON;
          w_timerNext  = ON_LOAD;
          w_startBlink = 1'b1;
        end else begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_timerNext = '0;
      end
    endcase
  end

  // LED is decoded from the state register alone so an asynchronous reset
  // darkens it immediately, without waiting for a clock edge.
  assign led     = (r_state != ON);
  assign busy    = (r_state != IDLE) || w_havePending;
  assign pending = w_pending;
  assign dropped = w_overflow;

endmodule

// File: tb/tb_led_blink_output.sv
// ---------------------------------------------------------------------------
// tb_led_blink_output
// Bench for led_blink_output with default parameters (ON=4, OFF=4, MAX=3).
// The reference model keeps a list of scheduled blink start edges: an
// accepted trigger at edge e starts its blink at the later of e+1 and the
// previous blink start plus one full period. Outputs are derived from that
// schedule and compared every cycle, with a few fixed expectations per test.
// ---------------------------------------------------------------------------
module tb_led_blink_output;

  localparam int ON_C   = 4;
  localparam int OFF_C  = 4;
  localparam int MAX_P  = 3;
  localparam int PERIOD = ON_C + OFF_C;

  logic       clk = 1'b0;
  logic       reset;
  logic       trigger;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       dropped;

  int checkCount = 0;
  int errorCount = 0;

  int startQ[$];
  int lastStart;
  bit anyStarted;
  int edgeNo;
  bit modelDropped;

  led_blink_output #(
    .ON_CYCLES   (ON_C),
    .OFF_CYCLES  (OFF_C),
    .MAX_PENDING (MAX_P)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  task automatic compareBit(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b, expected %b (edge %0d)", name, actual, expected, edgeNo);
    end
  endtask

  task automatic compareVec(input string name, input logic [1:0] actual, input logic [1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeNo);
    end
  endtask

  task automatic modelReset();
    startQ.delete();
    anyStarted   = 1'b0;
    lastStart    = 0;
    modelDropped = 1'b0;
  endtask

  // Advance the schedule by one clock edge given the sampled trigger.
  task automatic modelEdge(input logic trig);
    int  e;
    int  base;
    int  ns;
    bit  startsNow;
    edgeNo++;
    e = edgeNo;
    startsNow    = (startQ.size() > 0) && (startQ[0] == e);
    modelDropped = 1'b0;
    if (trig) begin
      if (startsNow || (startQ.size() < MAX_P)) begin
        if (startQ.size() > 0) begin
          base = startQ[startQ.size()-1];
        end else if (anyStarted) begin
          base = lastStart;
        end else begin
          base = -1000;
        end
        ns = ((base + PERIOD) > (e + 1)) ? (base + PERIOD) : (e + 1);
        startQ.push_back(ns);
      end else begin
        modelDropped = 1'b1;
      end
    end
    if (startsNow) begin
      lastStart  = e;
      anyStarted = 1'b1;
      void'(startQ.pop_front());
    end
  endtask

  function automatic logic modelLed();
    return !(anyStarted && ((edgeNo - lastStart) < ON_C));
  endfunction

  function automatic logic modelBusy();
    return (startQ.size() > 0) || (anyStarted && ((edgeNo - lastStart) < PERIOD));
  endfunction

  task automatic checkOutput();
    compareBit("led", led, modelLed());
    compareBit("busy", busy, modelBusy());
    compareVec("pending", pending, 2'(startQ.size()));
    compareBit("dropped", dropped, modelDropped);
  endtask

  // Drive trigger for one cycle from a falling edge, update the model on the
  // rising edge, then check the outputs on the next falling edge.
  task automatic applyStimulus(input logic trig);
    trigger = trig;
    @(posedge clk);
    modelEdge(trig);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic runIdle(input int n);
    repeat (n) applyStimulus(1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    trigger = 1'b0;
    edgeNo  = 0;
    modelReset();

    // Test 1: triggers during reset are ignored.
    trigger = 1'b1;
    repeat (3) begin
      @(negedge clk);
      compareBit("t1_rst_led", led, 1'b1);
      compareBit("t1_rst_busy", busy, 1'b0);
      compareVec("t1_rst_pending", pending, 2'd0);
      compareBit("t1_rst_dropped", dropped, 1'b0);
    end
    reset   = 1'b1;
    trigger = 1'b0;
    repeat (10) begin
      applyStimulus(1'b0);
      compareBit("t1_led", led, 1'b1);
      compareBit("t1_busy", busy, 1'b0);
    end

    // Test 2: single pulse, one blink.
    applyStimulus(1'b1);
    compareVec("t2_pending1", pending, 2'd1);
    compareBit("t2_led_dark_before", led, 1'b1);
    applyStimulus(1'b0);
    compareBit("t2_led_lit_first", led, 1'b0);
    repeat (3) applyStimulus(1'b0);
    compareBit("t2_led_lit_last", led, 1'b0);
    applyStimulus(1'b0);
    compareBit("t2_led_dark_after", led, 1'b1);
    repeat (3) applyStimulus(1'b0);
    compareBit("t2_busy_in_gap", busy, 1'b1);
    applyStimulus(1'b0);
    compareBit("t2_busy_done", busy, 1'b0);
    runIdle(4);

    // Test 3: three consecutive pulses, three back-to-back blinks.
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    compareVec("t3_pending_peak", pending, 2'd2);
    runIdle(30);
    compareBit("t3_busy_done", busy, 1'b0);

    // Test 4: five pulses, the fifth is dropped.
    repeat (4) applyStimulus(1'b1);
    compareVec("t4_pending_full", pending, 2'd3);
    compareBit("t4_no_drop_yet", dropped, 1'b0);
    applyStimulus(1'b1);
    compareBit("t4_dropped", dropped, 1'b1);
    compareVec("t4_pending_sat", pending, 2'd3);
    applyStimulus(1'b0);
    compareBit("t4_dropped_clear", dropped, 1'b0);
    runIdle(40);
    compareBit("t4_busy_done", busy, 1'b0);

    // Test 5: trigger on the last gap cycle with one blink queued.
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    runIdle(7);
    compareBit("t5_led_gap_end", led, 1'b1);
    applyStimulus(1'b1);
    compareVec("t5_pending_hold", pending, 2'd1);
    compareBit("t5_led_restart", led, 1'b0);
    compareBit("t5_busy", busy, 1'b1);
    runIdle(30);
    compareBit("t5_busy_done", busy, 1'b0);

    // Test 6: asynchronous reset during an ON window with two queued.
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    compareBit("t6_led_on", led, 1'b0);
    compareVec("t6_pending2", pending, 2'd2);
    #2;
    reset = 1'b0;
    #1;
    compareBit("t6_rst_led", led, 1'b1);
    compareVec("t6_rst_pending", pending, 2'd0);
    compareBit("t6_rst_busy", busy, 1'b0);
    compareBit("t6_rst_dropped", dropped, 1'b0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    runIdle(20);
    compareBit("t6_led_after", led, 1'b1);
    compareBit("t6_busy_after", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
